// File: rtl/proc_datapath.sv
// Register file, wired-OR operand buses, ALU and G register with an iterative
// 16-step restoring divider that holds `busy` while it runs.
module proc_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREGS-1:0]         reg_en,
  input  logic [NREGS-1:0]         bus1_buf_en,
  input  logic [NREGS-1:0]         bus2_buf_en,
  input  logic                     data_out,
  input  logic [WIDTH-1:0]         imm,
  input  logic                     g_in,
  input  logic                     g_out,
  input  logic [6:0]               math_enables,
  output logic [WIDTH-1:0]         bus1,
  output logic [WIDTH-1:0]         bus2,
  output logic [WIDTH-1:0]         g_value,
  output logic                     busy,
  output logic                     div_by_zero,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [WIDTH-1:0]         dbg_data
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [NREGS-1:0][WIDTH-1:0] r_regs;
  logic [WIDTH-1:0] r_g, r_q, r_b, r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_dbz, r_mod;

  logic [WIDTH-1:0] w_bus1, w_bus2, w_alu, w_wr_data, w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic [WIDTH:0]   w_rem_sh, w_diff;
  logic             w_wr_en, w_move, w_onehot, w_cap, w_is_dm, w_ge;

  always_comb begin
    w_bus1 = '0;
    w_bus2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus1_buf_en[i]) w_bus1 = w_bus1 | r_regs[i];
      if (bus2_buf_en[i]) w_bus2 = w_bus2 | r_regs[i];
    end
  end

  always_comb begin
    w_alu = '0;
    case (math_enables)
      7'b1000000: w_alu = w_bus1 ^ w_bus2;
      7'b0100000: w_alu = w_bus1 + w_bus2;
      7'b0010000: w_alu = w_bus1 - w_bus2;
      7'b0001000: w_alu = w_bus1 & w_bus2;
      7'b0000100: w_alu = w_bus1 | w_bus2;
      default:    w_alu = '0;
    endcase
  end

  assign w_onehot = (math_enables != 7'd0) &&
                    ((math_enables & (math_enables - 7'd1)) == 7'd0);
  assign w_cap    = g_in && !g_out && !r_busy && w_onehot;
  assign w_is_dm  = |math_enables[1:0];

  // A plain move is the only write that uses bus1 as its source.
  assign w_move = !g_in && (math_enables == 7'd0) && (|bus1_buf_en) &&
                  (bus2_buf_en == '0);

  always_comb begin
    w_wr_en   = 1'b1;
    w_wr_data = '0;
    if (data_out)              w_wr_data = imm;
    else if (g_out && !r_busy) w_wr_data = r_g;
    else if (w_move)           w_wr_data = w_bus1;
    else                       w_wr_en   = 1'b0;
  end

  // One restoring step: shift the next dividend bit into the remainder, trial-subtract.
  assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_ge     = !w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
      r_g    <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_dbz  <= 1'b0;
      r_mod  <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (w_wr_en && reg_en[i]) r_regs[i] <= w_wr_data;

      if (r_busy) begin
        r_rem <= w_rem_nx;
        r_q   <= w_q_nx;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_g    <= r_mod ? w_rem_nx : w_q_nx;
        end
      end else if (w_cap) begin
        if (!w_is_dm) begin
          r_g <= w_alu;
        end else if (w_bus2 == '0) begin
          r_g   <= math_enables[1] ? '1 : w_bus1;
          r_dbz <= 1'b1;
        end else begin
          r_q    <= w_bus1;
          r_b    <= w_bus2;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_mod  <= math_enables[0];
          r_busy <= 1'b1;
        end
      end
    end
  end

  assign bus1        = w_bus1;
  assign bus2        = w_bus2;
  assign g_value     = r_g;
  assign busy        = r_busy;
  assign div_by_zero = r_dbz;
  assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_proc_datapath.sv
// Table-driven vectors through a scoreboard queue, plus hand sequences for the
// divider (busy length, ignored g_out, latched operands) and reset mid-divide.
module tb_proc_datapath;
  localparam logic [6:0] XOR_ = 7'b1000000, ADD = 7'b0100000, SUB = 7'b0010000,
                         AND_ = 7'b0001000, OR_ = 7'b0000100, DIV = 7'b0000010,
                         MOD = 7'b0000001;

  logic clk = 0, reset = 1;
  logic [7:0] reg_en = 0, b1en = 0, b2en = 0;
  logic data_out = 0, g_in = 0, g_out = 0;
  logic [15:0] imm = 0;
  logic [6:0] me = 0;
  logic [2:0] dbg_sel = 0;
  logic [15:0] bus1, bus2, g_value, dbg_data;
  logic busy, div_by_zero;

  int n_cmp = 0, n_err = 0;

  proc_datapath dut (
    .clk(clk), .reset(reset), .reg_en(reg_en), .bus1_buf_en(b1en),
    .bus2_buf_en(b2en), .data_out(data_out), .imm(imm), .g_in(g_in),
    .g_out(g_out), .math_enables(me), .bus1(bus1), .bus2(bus2),
    .g_value(g_value), .busy(busy), .div_by_zero(div_by_zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dout;
    logic [15:0] imm;
    logic [7:0]  ren, b1, b2;
    logic        gi, go;
    logic [6:0]  me;
    logic [2:0]  dsel;
    logic [15:0] exp_dbg, exp_g;
    logic        exp_dbz;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] dbg, g;
    logic        dbz;
  } exp_t;

  vec_t tbl[22];
  exp_t sb[$];

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %h expected %h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic d, input logic [15:0] im, input logic [7:0] re,
                              input logic [7:0] a, input logic [7:0] b, input logic gi,
                              input logic go, input logic [6:0] m, input logic [2:0] ds,
                              input logic [15:0] ed, input logic [15:0] eg, input logic ez);
    vec_t v;
    v.dout = d; v.imm = im; v.ren = re; v.b1 = a; v.b2 = b; v.gi = gi; v.go = go;
    v.me = m; v.dsel = ds; v.exp_dbg = ed; v.exp_g = eg; v.exp_dbz = ez;
    return v;
  endfunction

  task automatic idle();
    data_out = 0; imm = 0; reg_en = 0; b1en = 0; b2en = 0; g_in = 0; g_out = 0; me = 0;
  endtask

  task automatic load(input int r, input logic [15:0] v);
    idle(); data_out = 1; imm = v; reg_en = 8'(1 << r);
    @(negedge clk);
    idle();
  endtask

  task automatic run_div(input logic [6:0] op, input logic [15:0] exp_g, input string nm);
    int cnt;
    idle(); g_in = 1; me = op; b1en = 8'h02; b2en = 8'h08;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 40) begin
      cnt++;
      g_out = 0; data_out = 0; reg_en = 0;
      if (cnt == 3) begin g_out = 1; reg_en = 8'h80; end
      if (cnt == 4) begin data_out = 1; imm = 16'h5555; reg_en = 8'h40; end
      if (cnt == 6) b1en = 8'h01;
      @(negedge clk);
    end
    idle();
    chk({nm, "_busy_cycles"}, 0, 16'(cnt), 16'd16);
    chk({nm, "_g"}, 0, g_value, exp_g);
    dbg_sel = 7; #1 chk({nm, "_r7_kept"}, 0, dbg_data, 16'h0001);
    dbg_sel = 6; #1 chk({nm, "_r6_load"}, 0, dbg_data, 16'h5555);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int n;
    //               dout imm      ren    b1     b2     gi go me     ds  dbg      g        dbz
    tbl[0]  = mk(1, 16'h1234, 8'h04, 8'h00, 8'h00, 0, 0, 7'd0, 2, 16'h1234, 16'h0000, 0);
    tbl[1]  = mk(0, 16'h0000, 8'hFF, 8'h00, 8'h00, 0, 0, 7'd0, 2, 16'h1234, 16'h0000, 0);
    tbl[2]  = mk(0, 16'h0000, 8'h20, 8'h04, 8'h00, 0, 0, 7'd0, 5, 16'h1234, 16'h0000, 0);
    tbl[3]  = mk(0, 16'h0000, 8'h40, 8'h04, 8'h01, 0, 0, 7'd0, 6, 16'h0000, 16'h0000, 0);
    tbl[4]  = mk(1, 16'hFFFF, 8'h01, 8'h00, 8'h00, 0, 0, 7'd0, 0, 16'hFFFF, 16'h0000, 0);
    tbl[5]  = mk(1, 16'h0002, 8'h02, 8'h00, 8'h00, 0, 0, 7'd0, 1, 16'h0002, 16'h0000, 0);
    tbl[6]  = mk(0, 16'h0000, 8'h00, 8'h01, 8'h02, 1, 0, ADD,  1, 16'h0002, 16'h0001, 0);
    tbl[7]  = mk(0, 16'h0000, 8'h80, 8'h00, 8'h00, 0, 1, 7'd0, 7, 16'h0001, 16'h0001, 0);
    tbl[8]  = mk(0, 16'h0000, 8'h08, 8'h01, 8'h02, 1, 1, SUB,  3, 16'h0001, 16'h0001, 0);
    tbl[9]  = mk(1, 16'h0003, 8'h08, 8'h00, 8'h00, 0, 0, 7'd0, 3, 16'h0003, 16'h0001, 0);
    tbl[10] = mk(1, 16'h0005, 8'h10, 8'h00, 8'h00, 0, 0, 7'd0, 4, 16'h0005, 16'h0001, 0);
    tbl[11] = mk(0, 16'h0000, 8'h00, 8'h08, 8'h10, 1, 0, SUB,  4, 16'h0005, 16'hFFFE, 0);
    tbl[12] = mk(0, 16'h0000, 8'h00, 8'h01, 8'h08, 1, 0, XOR_, 0, 16'hFFFF, 16'hFFFC, 0);
    tbl[13] = mk(0, 16'h0000, 8'h00, 8'h04, 8'h10, 1, 0, AND_, 0, 16'hFFFF, 16'h0004, 0);
    tbl[14] = mk(0, 16'h0000, 8'h00, 8'h04, 8'h10, 1, 0, OR_,  0, 16'hFFFF, 16'h1235, 0);
    tbl[15] = mk(0, 16'h0000, 8'h00, 8'h14, 8'h08, 1, 0, ADD,  0, 16'hFFFF, 16'h1238, 0);
    tbl[16] = mk(0, 16'h0000, 8'h00, 8'h01, 8'h02, 1, 0, 7'b1100000, 0, 16'hFFFF, 16'h1238, 0);
    tbl[17] = mk(1, 16'hBEEF, 8'h01, 8'h00, 8'h00, 0, 1, 7'd0, 0, 16'hBEEF, 16'h1238, 0);
    tbl[18] = mk(1, 16'h00AA, 8'h02, 8'h00, 8'h00, 0, 0, 7'd0, 1, 16'h00AA, 16'h1238, 0);
    tbl[19] = mk(0, 16'h0000, 8'h00, 8'h02, 8'h40, 1, 0, DIV,  1, 16'h00AA, 16'hFFFF, 1);
    tbl[20] = mk(0, 16'h0000, 8'h00, 8'h02, 8'h40, 1, 0, MOD,  1, 16'h00AA, 16'h00AA, 1);
    tbl[21] = mk(0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0, 7'd0, 7, 16'h0001, 16'h00AA, 1);

    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    b1en = 8'hFF; b2en = 8'hFF; dbg_sel = 3;
    #1;
    chk("rst_bus1", 0, bus1, 16'h0); chk("rst_bus2", 0, bus2, 16'h0);
    chk("rst_g", 0, g_value, 16'h0); chk("rst_dbg", 0, dbg_data, 16'h0);
    chk("rst_busy", 0, 16'(busy), 16'h0); chk("rst_dbz", 0, 16'(div_by_zero), 16'h0);
    @(negedge clk);
    reset = 0; idle();

    for (int i = 0; i < 22; i++) begin
      data_out = tbl[i].dout; imm = tbl[i].imm; reg_en = tbl[i].ren;
      b1en = tbl[i].b1; b2en = tbl[i].b2; g_in = tbl[i].gi; g_out = tbl[i].go;
      me = tbl[i].me; dbg_sel = tbl[i].dsel;
      sb.push_back('{id: i, dbg: tbl[i].exp_dbg, g: tbl[i].exp_g, dbz: tbl[i].exp_dbz});
      @(negedge clk);
      idle();
      #1;
      e = sb.pop_front();
      chk("vec_dbg", e.id, dbg_data, e.dbg);
      chk("vec_g", e.id, g_value, e.g);
      chk("vec_dbz", e.id, 16'(div_by_zero), 16'(e.dbz));
      chk("vec_busy", e.id, 16'(busy), 16'h0);
      @(negedge clk);
    end

    load(1, 16'd100);
    load(3, 16'd7);
    run_div(DIV, 16'd14, "div");
    load(1, 16'd100);
    run_div(MOD, 16'd2, "mod");

    idle(); g_in = 1; me = DIV; b1en = 8'h02; b2en = 8'h08;
    n = 0;
    @(negedge clk);
    while (busy && n < 7) begin n++; @(negedge clk); end
    chk("pre_rst_busy", 0, 16'(busy), 16'h1);
    reset = 1;
    @(negedge clk);
    reset = 0; idle(); dbg_sel = 1;
    #1;
    chk("midrst_busy", 0, 16'(busy), 16'h0);
    chk("midrst_g", 0, g_value, 16'h0);
    chk("midrst_dbz", 0, 16'(div_by_zero), 16'h0);
    chk("midrst_r1", 0, dbg_data, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
